// File: rtl/fpu_sched.sv
// fpu_sched -- issue controller for the shared FPU units of the single-cycle core.
//
// One FPU operation is accepted per req_valid/req_ready handshake. The operand
// registers captured at accept drive the combinational add/sub and multiply
// units and the pipelined divider. Single-cycle ops spend one cycle in EXEC.
// A divide waits in DIV_WAIT until the divider answers or a timeout expires.
// Every result leaves through one registered write-back port as a one-cycle
// wb_valid pulse.
//
// Optional feature: define FPU_SCHED_PERF_EN to add the perf_ops and
// perf_div_wait saturating counters and their output ports.
//
// Ports
//   CLK, RST_N              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake
//   req_op                  0 add, 1 sub, 2 mul, 3 div, 4 mov, 5-7 illegal
//   req_rd, req_a, req_b    destination register and operands (a = fs, b = ft)
//   fas_a/fas_b/fas_op      add/sub unit operands (fas_op: 0 add, 1 sub)
//   fas_res                 add/sub unit result
//   fmul_a/fmul_b/fmul_res  multiplier operands and result
//   fdiv_a/fdiv_b           divider operands
//   fdiv_in_valid           divider input valid, one cycle per divide
//   fdiv_res_valid/fdiv_res divider result handshake
//   wb_valid/wb_rd/wb_data  write-back pulse; rd/data hold between pulses
//   busy                    not IDLE, or a write-back is pending
//   err                     sticky error (illegal op or lost divide)
//   perf_ops, perf_div_wait accept count and DIV_WAIT cycle count (optional)
module fpu_sched #(
    parameter int DIV_LAT   = 28,
    parameter int TMO_SLACK = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    output logic [31:0] fas_a,
    output logic [31:0] fas_b,
    output logic        fas_op,
    input  logic [31:0] fas_res,
    output logic [31:0] fmul_a,
    output logic [31:0] fmul_b,
    input  logic [31:0] fmul_res,
    output logic [31:0] fdiv_a,
    output logic [31:0] fdiv_b,
    output logic        fdiv_in_valid,
    input  logic        fdiv_res_valid,
    input  logic [31:0] fdiv_res,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        err
`ifdef FPU_SCHED_PERF_EN
    ,
    output logic [31:0] perf_ops,
    output logic [31:0] perf_div_wait
`endif
);

    localparam int          DATA_W  = 32;
    localparam int          TMO_CYC = DIV_LAT + TMO_SLACK;
    localparam int          CNT_W   = $clog2(TMO_CYC + 1);
    localparam logic [CNT_W-1:0]  TMO_CNT = CNT_W'(TMO_CYC);
    localparam logic [DATA_W-1:0] QNAN    = 32'h7FC0_0000;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOV = 3'd4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        DIV_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          op_q;
    logic [4:0]          rd_q;
    logic [DATA_W-1:0]   a_q, b_q;
    logic                wb_valid_q, wb_valid_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;
    logic                err_q, err_d;

    logic                accept;
    state_e              issue_state;
    logic                issue_illegal;

    // Result of a single-cycle op, selected from the unit outputs that the
    // operand registers are currently driving.
    function automatic logic [DATA_W-1:0] exec_result(
        input logic [2:0]        op,
        input logic [DATA_W-1:0] as_res,
        input logic [DATA_W-1:0] mul_res,
        input logic [DATA_W-1:0] opnd_b
    );
        logic [DATA_W-1:0] res;
        case (op)
            OP_ADD, OP_SUB: res = as_res;
            OP_MUL:         res = mul_res;
            default:        res = opnd_b;
        endcase
        return res;
    endfunction

    // A divide blocks issue, which is what keeps write-backs in issue order.
    assign req_ready = (state_q != DIV_WAIT);
    assign accept    = req_valid && req_ready;

    always_comb begin : issue_decode
        issue_state   = EXEC;
        issue_illegal = 1'b0;
        case (req_op)
            OP_ADD, OP_SUB, OP_MUL, OP_MOV: issue_state = EXEC;
            OP_DIV:                         issue_state = DIV_WAIT;
            default: begin
                issue_state   = IDLE;
                issue_illegal = 1'b1;
            end
        endcase
    end

    always_comb begin : next_state
        state_d    = state_q;
        cnt_d      = cnt_q;
        wb_valid_d = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_data_d  = wb_data_q;
        err_d      = err_q;

        case (state_q)
            EXEC: begin
                wb_valid_d = 1'b1;
                wb_rd_d    = rd_q;
                wb_data_d  = exec_result(op_q, fas_res, fmul_res, b_q);
                state_d    = IDLE;
            end
            DIV_WAIT: begin
                // A result arriving on the timeout cycle still wins.
                if (fdiv_res_valid) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = fdiv_res;
                    state_d    = IDLE;
                end else if (cnt_q == TMO_CNT) begin
                    err_d      = 1'b1;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = QNAN;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Accept is only possible outside DIV_WAIT, so it may override the
        // EXEC return-to-IDLE to give back-to-back issue.
        if (accept) begin
            state_d = issue_state;
            cnt_d   = '0;
            if (issue_illegal) begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    // Operand registers: frozen between accepts so the units see stable inputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            op_q <= '0;
            rd_q <= '0;
            a_q  <= '0;
            b_q  <= '0;
        end else if (accept) begin
            op_q <= req_op;
            rd_q <= req_rd;
            a_q  <= req_a;
            b_q  <= req_b;
        end
    end

    assign fas_a         = a_q;
    assign fas_b         = b_q;
    assign fas_op        = (op_q == OP_SUB);
    assign fmul_a        = a_q;
    assign fmul_b        = b_q;
    assign fdiv_a        = a_q;
    assign fdiv_b        = b_q;
    assign fdiv_in_valid = (state_q == DIV_WAIT) && (cnt_q == '0);

    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_data_q;
    assign busy     = (state_q != IDLE) || wb_valid_q;
    assign err      = err_q;

`ifdef FPU_SCHED_PERF_EN
    logic [31:0] perf_ops_q, perf_div_wait_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            perf_ops_q      <= '0;
            perf_div_wait_q <= '0;
        end else begin
            if (accept && (perf_ops_q != '1)) begin
                perf_ops_q <= perf_ops_q + 32'd1;
            end
            if ((state_q == DIV_WAIT) && (perf_div_wait_q != '1)) begin
                perf_div_wait_q <= perf_div_wait_q + 32'd1;
            end
        end
    end

    assign perf_ops      = perf_ops_q;
    assign perf_div_wait = perf_div_wait_q;
`endif

endmodule

// File: tb/tb_fpu_sched.sv
// Self-checking bench for fpu_sched: directed scenarios followed by a
// randomized mix of ops, all checked against a transaction-level model.
module tb_fpu_sched;

    localparam int DIV_LAT   = 28;
    localparam int TMO_SLACK = 4;
    localparam int TMO       = DIV_LAT + TMO_SLACK;

    logic        CLK;
    logic        RST_N;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_rd;
    logic [31:0] req_a, req_b;
    logic [31:0] fas_a, fas_b, fas_res;
    logic        fas_op;
    logic [31:0] fmul_a, fmul_b, fmul_res;
    logic [31:0] fdiv_a, fdiv_b, fdiv_res;
    logic        fdiv_in_valid, fdiv_res_valid;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        busy, err;
`ifdef FPU_SCHED_PERF_EN
    logic [31:0] perf_ops, perf_div_wait;
`endif

    // Expected architectural state of the scheduler
    logic        exp_v;
    logic [4:0]  exp_rd;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_ops, exp_dw;

    int          n_cmp, n_bad;
    int          r;
    logic [31:0] ra, rb, rc;
    logic [4:0]  rrd;
    logic [2:0]  rop;

    fpu_sched #(.DIV_LAT(DIV_LAT), .TMO_SLACK(TMO_SLACK)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_op         (req_op),
        .req_rd         (req_rd),
        .req_a          (req_a),
        .req_b          (req_b),
        .fas_a          (fas_a),
        .fas_b          (fas_b),
        .fas_op         (fas_op),
        .fas_res        (fas_res),
        .fmul_a         (fmul_a),
        .fmul_b         (fmul_b),
        .fmul_res       (fmul_res),
        .fdiv_a         (fdiv_a),
        .fdiv_b         (fdiv_b),
        .fdiv_in_valid  (fdiv_in_valid),
        .fdiv_res_valid (fdiv_res_valid),
        .fdiv_res       (fdiv_res),
        .wb_valid       (wb_valid),
        .wb_rd          (wb_rd),
        .wb_data        (wb_data),
        .busy           (busy),
        .err            (err)
`ifdef FPU_SCHED_PERF_EN
        ,
        .perf_ops       (perf_ops),
        .perf_div_wait  (perf_div_wait)
`endif
    );

    // Stand-in unit models: 1.0 + 2.0 returns 3.0; otherwise integer arithmetic
    // is enough to tell the units and operands apart.
    function automatic logic [31:0] fadd_m(input logic [31:0] a, input logic [31:0] b,
                                           input logic sub);
        if (!sub && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        return sub ? (a - b) : (a + b);
    endfunction

    function automatic logic [31:0] fmul_m(input logic [31:0] a, input logic [31:0] b);
        return a * b;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
        case (op)
            3'd0:    return fadd_m(a, b, 1'b0);
            3'd1:    return fadd_m(a, b, 1'b1);
            3'd2:    return fmul_m(a, b);
            default: return b;
        endcase
    endfunction

    assign fas_res  = fadd_m(fas_a, fas_b, fas_op);
    assign fmul_res = fmul_m(fmul_a, fmul_b);

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, required finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_wb(input string tag);
        chk({tag, "_wbv"},  32'(wb_valid), 32'(exp_v));
        chk({tag, "_wbrd"}, 32'(wb_rd),    32'(exp_rd));
        chk({tag, "_wbd"},  wb_data,       exp_data);
        chk({tag, "_err"},  32'(err),      32'(exp_err));
    endtask

    task automatic check_perf(input string tag);
`ifdef FPU_SCHED_PERF_EN
        chk({tag, "_perf_ops"}, perf_ops,      32'(exp_ops));
        chk({tag, "_perf_dw"},  perf_div_wait, 32'(exp_dw));
`endif
    endtask

    task automatic reset_model();
        exp_v    = 1'b0;
        exp_rd   = '0;
        exp_data = '0;
        exp_err  = 1'b0;
        exp_ops  = 0;
        exp_dw   = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 32'(req_ready),     32'd1);
        chk({tag, "_inv"},   32'(fdiv_in_valid), 32'd0);
        chk({tag, "_busy"},  32'(busy),          32'd0);
        chk({tag, "_fasa"},  fas_a,  32'd0);
        chk({tag, "_fasb"},  fas_b,  32'd0);
        chk({tag, "_fasop"}, 32'(fas_op), 32'd0);
        chk({tag, "_mula"},  fmul_a, 32'd0);
        chk({tag, "_mulb"},  fmul_b, 32'd0);
        chk({tag, "_diva"},  fdiv_a, 32'd0);
        chk({tag, "_divb"},  fdiv_b, 32'd0);
        check_wb(tag);
        check_perf(tag);
    endtask

    // Present a non-divide op, accept it, check the previous write-back slot
    // and record what this op must write back on the next edge.
    task automatic issue_op(input logic [2:0] op, input logic [4:0] rd,
                            input logic [31:0] a, input logic [31:0] b);
        req_valid = 1'b1;
        req_op    = op;
        req_rd    = rd;
        req_a     = a;
        req_b     = b;
        chk("issue_ready", 32'(req_ready), 32'd1);
        cyc();
        exp_ops++;
        if (op >= 3'd5) exp_err = 1'b1;
        check_wb("issue");
        chk("opnd_fas_a",  fas_a,  a);
        chk("opnd_fmul_b", fmul_b, b);
        chk("opnd_fas_op", 32'(fas_op), 32'(op == 3'd1));
        if (op >= 3'd5) begin
            exp_v = 1'b0;
        end else begin
            exp_v    = 1'b1;
            exp_rd   = rd;
            exp_data = ref_result(op, a, b);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        cyc();
        check_wb("idle");
        exp_v = 1'b0;
    endtask

    // Divide whose result arrives in wait cycle d (0 = the fdiv_in_valid cycle);
    // d beyond the timeout window means the divider never answers. With hold set,
    // an add (rd 9, 5 + 7) is presented throughout the wait.
    task automatic do_div(input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] dres, input int d, input logic hold);
        bit done;
        req_valid = 1'b1;
        req_op    = 3'd3;
        req_rd    = rd;
        req_a     = a;
        req_b     = b;
        chk("div_ready_in", 32'(req_ready), 32'd1);
        cyc();
        exp_ops++;
        check_wb("div_prev");
        exp_v = 1'b0;
        chk("div_opnd_a", fdiv_a, a);
        chk("div_opnd_b", fdiv_b, b);
        if (hold) begin
            req_op = 3'd0;
            req_rd = 5'd9;
            req_a  = 32'd5;
            req_b  = 32'd7;
        end else begin
            req_valid = 1'b0;
        end
        done = 1'b0;
        for (int k = 0; k <= TMO && !done; k++) begin
            chk("div_ready_low", 32'(req_ready),     32'd0);
            chk("div_in_valid",  32'(fdiv_in_valid), 32'(k == 0));
            chk("div_busy",      32'(busy),          32'd1);
            fdiv_res_valid = (k == d);
            fdiv_res       = dres;
            cyc();
            fdiv_res_valid = 1'b0;
            exp_dw++;
            if (k == d) begin
                exp_v    = 1'b1;
                exp_rd   = rd;
                exp_data = dres;
                done     = 1'b1;
            end else if (k == TMO) begin
                exp_v    = 1'b1;
                exp_rd   = rd;
                exp_data = 32'h7FC0_0000;
                exp_err  = 1'b1;
                done     = 1'b1;
            end
            check_wb("div_wait");
        end
        chk("div_ready_back", 32'(req_ready), 32'd1);
        chk("div_busy_wb",    32'(busy),      32'd1);
        exp_v = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset_model();
        RST_N = 1'b0;
        req_valid = 1'b0;
        req_op = '0;
        req_rd = '0;
        req_a = '0;
        req_b = '0;
        fdiv_res_valid = 1'b0;
        fdiv_res = '0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset("por");
        @(negedge CLK);
        RST_N = 1'b1;
        cyc();
        check_wb("post_rst");

        // Single add: write-back one edge after the capture edge
        issue_op(3'd0, 5'd4, 32'h3F80_0000, 32'h4000_0000);
        chk("add_busy", 32'(busy), 32'd1);
        idle();
        chk("add_wb_ready", 32'(req_ready), 32'd1);
        idle();
        chk("add_idle_busy", 32'(busy), 32'd0);

        // Divide answering after 28 cycles with an add held during the wait
        do_div(5'd7, 32'h4228_0000, 32'h4000_0000, 32'h41A8_0000, DIV_LAT - 1, 1'b1);
        check_perf("s6");
        issue_op(3'd0, 5'd9, 32'd5, 32'd7);
        idle();
        idle();

        // Back-to-back mul then mov
        issue_op(3'd2, 5'd1, 32'h0001_0003, 32'h0000_0105);
        issue_op(3'd4, 5'd2, 32'h1111_2222, 32'hCAFE_F00D);
        idle();
        idle();

        // Lost divide result, sticky err, spurious late result, then normal add
        do_div(5'd3, 32'h4100_0000, 32'h0, 32'h0, TMO + 10, 1'b0);
        idle();
        fdiv_res_valid = 1'b1;
        fdiv_res       = 32'hDEAD_BEEF;
        idle();
        fdiv_res_valid = 1'b0;
        idle();
        issue_op(3'd1, 5'd5, 32'd100, 32'd58);
        idle();
        idle();

        // Reset in the middle of DIV_WAIT, then a late divider result
        req_valid = 1'b1;
        req_op    = 3'd3;
        req_rd    = 5'd12;
        req_a     = 32'h1234_5678;
        req_b     = 32'h9ABC_DEF0;
        cyc();
        req_valid = 1'b0;
        repeat (5) cyc();
        RST_N = 1'b0;
        #1;
        reset_model();
        check_reset("mid_rst");
        @(negedge CLK);
        RST_N = 1'b1;
        fdiv_res_valid = 1'b1;
        fdiv_res       = 32'h3333_3333;
        cyc();
        fdiv_res_valid = 1'b0;
        check_reset("late_res");
        cyc();
        check_wb("late_res2");

        // Illegal op: err, no write-back, stays idle
        issue_op(3'd6, 5'd8, 32'h5555_5555, 32'hAAAA_AAAA);
        chk("illegal_busy", 32'(busy), 32'd0);
        idle();
        idle();

        // Randomized mix
        for (int it = 0; it < 120; it++) begin
            r   = int'($urandom_range(0, 19));
            ra  = $urandom;
            rb  = $urandom;
            rc  = $urandom;
            rrd = 5'($urandom);
            if (r < 14) begin
                case ($urandom_range(0, 3))
                    0:       rop = 3'd0;
                    1:       rop = 3'd1;
                    2:       rop = 3'd2;
                    default: rop = 3'd4;
                endcase
                issue_op(rop, rrd, ra, rb);
            end else if (r < 18) begin
                do_div(rrd, ra, rb, rc, int'($urandom_range(0, TMO + 4)), 1'b0);
            end else begin
                issue_op(3'(5 + $urandom_range(0, 2)), rrd, ra, rb);
            end
            if ($urandom_range(0, 2) == 0) idle();
        end
        idle();
        idle();
        check_perf("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
